// File: rtl/gf2_mul64_seq_ctrl.sv
// rtl/gf2_mul64_seq_ctrl.sv - sequential carry-less 64x64 multiply controller, two A bytes per cycle
module gf2_mul64_seq_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  a_in,
  input  logic [63:0]  b_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] product,
  output logic [63:0]  lut_a_poly,
  output logic [63:0]  lut_b,
  input  logic [127:0] lut_d1,
  input  logic [127:0] lut_d2
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [63:0]    a_q, a_d;
  logic [63:0]    b_q, b_d;
  logic [127:0]   acc_q, acc_d;
  logic [127:0]   product_q, product_d;
  logic [7:0]     mask_q, mask_d;

  logic [7:0]     init_mask;
  logic [2:0]     idx1, idx2;
  logic           has2;
  logic [7:0]     mask_rem;
  logic [7:0]     mask_clr;
  logic [7:0]     byte1, byte2;
  logic [3:0]     pos1, pos2;

  always_comb begin
    init_mask = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (SKIP_ZERO) init_mask[i] = |a_in[i*8 +: 8];
    end
  end

  // Slot 1 takes the highest pending byte, slot 2 the next one below it.
  always_comb begin
    idx1 = 3'd0;
    idx2 = 3'd0;
    has2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (mask_q[i]) idx1 = i[2:0];
    end
    mask_rem = mask_q & ~(8'd1 << idx1);
    for (int i = 0; i < 8; i++) begin
      if (mask_rem[i]) begin
        idx2 = i[2:0];
        has2 = 1'b1;
      end
    end
    mask_clr = has2 ? (mask_rem & ~(8'd1 << idx2)) : mask_rem;
    byte1 = a_q[{idx1, 3'b000} +: 8];
    pos1  = {1'b0, idx1};
    byte2 = has2 ? a_q[{idx2, 3'b000} +: 8] : 8'h00;
    pos2  = has2 ? {1'b0, idx2} : 4'd0;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    mask_d    = mask_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a_in;
          b_d    = b_in;
          acc_d  = '0;
          mask_d = init_mask;
          if (init_mask == 8'h00) begin
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d  = acc_q ^ lut_d1 ^ lut_d2;
        mask_d = mask_clr;
        if (mask_clr == 8'h00) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      mask_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      mask_q    <= mask_d;
      product_q <= product_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign product    = product_q;
  assign lut_b      = b_q;
  assign lut_a_poly = (state_q == RUN) ? {40'd0, pos1, byte1, pos2, byte2} : 64'd0;

endmodule

// File: tb/tb_gf2_mul64_seq_ctrl.sv
// tb/tb_gf2_mul64_seq_ctrl.sv - scoreboard bench for both SKIP_ZERO settings of gf2_mul64_seq_ctrl
module tb_gf2_mul64_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  a_in, b_in;

  logic         busy1, done1, busy0, done0;
  logic [127:0] product1, product0;
  logic [63:0]  poly1, poly0, lb1, lb0;
  logic [127:0] d1_1, d2_1, d1_0, d2_0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] prod;
    int           cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] prod;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] clmul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) if (a[i]) r = r ^ ({64'd0, b} << i);
    return r;
  endfunction

  function automatic logic [127:0] pp(input logic [7:0] byt, input logic [3:0] pos, input logic [63:0] b);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (byt[i]) r = r ^ ({64'd0, b} << i);
    return r << (8 * pos);
  endfunction

  function automatic int n_skip(input logic [63:0] a);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (a[i*8 +: 8] != 8'h00) n++;
    return (n + 1) / 2;
  endfunction

  assign d1_1 = pp(poly1[19:12], poly1[23:20], lb1);
  assign d2_1 = pp(poly1[7:0],   poly1[11:8],  lb1);
  assign d1_0 = pp(poly0[19:12], poly0[23:20], lb0);
  assign d2_0 = pp(poly0[7:0],   poly0[11:8],  lb0);

  gf2_mul64_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy1), .done(done1), .product(product1),
    .lut_a_poly(poly1), .lut_b(lb1), .lut_d1(d1_1), .lut_d2(d2_1)
  );

  gf2_mul64_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy0), .done(done0), .product(product0),
    .lut_a_poly(poly0), .lut_b(lb0), .lut_d1(d1_0), .lut_d2(d2_0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Both instances retire in order; a done with nothing expected is an error.
  always @(negedge clk) begin
    if (!rst && done1) begin
      if (q1.size() == 0) chk("unexpected_done_skip1", 128'd1, 128'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("product_skip1", product1, e.prod);
        chk("done_cycle_skip1", 128'(cyc), 128'(e.cyc));
        chk("busy_in_done_skip1", {127'd0, busy1}, 128'd1);
        chk("poly_zero_in_done_skip1", {64'd0, poly1}, 128'd0);
      end
    end
    if (!rst && done0) begin
      if (q0.size() == 0) chk("unexpected_done_skip0", 128'd1, 128'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("product_skip0", product0, e.prod);
        chk("done_cycle_skip0", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [127:0] prod, input bit push);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    if (push) begin
      q1.push_back('{prod: prod, cyc: cyc + 1 + n_skip(a)});
      q0.push_back('{prod: prod, cyc: cyc + 5});
    end
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && (q1.size() != 0 || q0.size() != 0); k++) @(negedge clk);
    if (q1.size() != 0 || q0.size() != 0) begin
      chk("drain_timeout", 128'(q1.size() + q0.size()), 128'd0);
      q1.delete();
      q0.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0] a2, b2;
    int c;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {126'd0, busy1, busy0}, 128'd0);
    chk("reset_done", {126'd0, done1, done0}, 128'd0);
    chk("reset_product", product1 | product0, 128'd0);
    chk("reset_poly", {poly1, poly0}, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{64'h1, 64'hFFFFFFFFFFFFFFFF, 128'h0000000000000000FFFFFFFFFFFFFFFF};
    vecs[1] = '{64'h0, 64'h123456789ABCDEF0, 128'h0};
    vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'h55555555555555555555555555555555};
    vecs[3] = '{64'h8000000000000000, 64'h3, 128'h18000000000000000};
    vecs[4] = '{64'h2, 64'h2, 128'h4};
    vecs[5] = '{64'h00FF000000000001, 64'hDEADBEEF01234567, 128'h0};
    vecs[6] = '{64'h0101010101010101, 64'h8000000000000001, 128'h0};
    vecs[7] = '{64'h1200003400005600, 64'hCAFEF00D12345678, 128'h0};
    for (int i = 5; i < 8; i++) vecs[i].prod = clmul(vecs[i].a, vecs[i].b);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].prod, 1'b1);
      if (vecs[i].a == 64'h0) chk("poly_zero_a0", {64'd0, poly1}, 128'd0);
      if (vecs[i].a == 64'h8000000000000000) begin
        chk("poly_run_skip1", {64'd0, poly1}, 128'h780000);
        chk("poly_run_skip0", {64'd0, poly0}, 128'h780600);
        chk("lut_b_run", {64'd0, lb1}, 128'h3);
      end
      drain();
    end

    // Reset in the second RUN cycle aborts silently.
    issue(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {126'd0, busy1, busy0}, 128'd0);
    chk("abort_product", product1 | product0, 128'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(64'h2, 64'h2, 128'h4, 1'b1);
    drain();

    // Start held high: each instance re-arms only after returning to IDLE.
    a2 = 64'h1200003400005600;
    b2 = 64'hCAFEF00D12345678;
    @(negedge clk);
    c = cyc;
    a_in = 64'hFF; b_in = 64'h3; start = 1'b1;
    q1.push_back('{prod: clmul(64'hFF, 64'h3), cyc: c + 2});
    q1.push_back('{prod: clmul(a2, b2), cyc: c + 6});
    q0.push_back('{prod: clmul(64'hFF, 64'h3), cyc: c + 5});
    q0.push_back('{prod: clmul(a2, b2), cyc: c + 11});
    @(negedge clk);
    a_in = a2; b_in = b2;
    repeat (6) @(negedge clk);
    start = 1'b0;
    a_in = 64'h0; b_in = 64'h0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gf2_mul64_seq_ctrl.md
GF2_MUL64_SEQ_CTRL -- requirements
Module: gf2_mul64_seq_ctrl

Interface
REQ-001 SHALL have parameter SKIP_ZERO, default 1, meaning: when 1, all-zero bytes of the A operand are not issued to the datapath; when 0, all 8 bytes are issued.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request a multiplication; sampled only in IDLE.
REQ-005 SHALL have port a_in, input, 64, operand A; captured when start is accepted.
REQ-006 SHALL have port b_in, input, 64, operand B; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking product valid.
REQ-009 SHALL have port product, output, 128, carry-less product A*B over GF(2), unreduced.
REQ-010 SHALL have port lut_a_poly, output, 64, datapath A_Poly: [23:20] pos1, [19:12] byte1, [11:8] pos2, [7:0] byte2, [63:24] zero.
REQ-011 SHALL have port lut_b, output, 64, datapath B; equals the captured B register.
REQ-012 SHALL have port lut_d1, input, 128, datapath partial product for byte1, already shifted by pos1 bytes.
REQ-013 SHALL have port lut_d2, input, 128, datapath partial product for byte2, already shifted by pos2 bytes.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 IDLE: on start=1, SHALL capture A and B, clear the 128-bit accumulator, load the 8-bit pending mask (bit i = A byte i nonzero if SKIP_ZERO=1, else 8'hFF), then go to RUN, or to DONE if the mask is zero.
REQ-016 RUN, each cycle: byte1 = highest pending byte index, byte2 = next highest pending byte index; if only one byte is pending, slot2 SHALL drive byte 0x00 with pos 0.
REQ-017 RUN, each cycle: SHALL update accumulator ^= lut_d1 ^ lut_d2, treating the datapath as same-cycle combinational, and clear the two issued mask bits.
REQ-018 RUN SHALL exit to DONE on the edge where the updated mask becomes zero; product SHALL be registered from the final accumulator value on that edge.
REQ-019 Latency: RUN SHALL last ceil(popcount(nonzero A bytes)/2) cycles when SKIP_ZERO=1, and exactly 4 cycles when SKIP_ZERO=0.
REQ-020 Latency: with start high in cycle 0, done SHALL be high in cycle 1+N, where N = RUN cycles.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 product SHALL hold its value until the next DONE.
REQ-023 start SHALL be ignored in RUN and DONE; there is no queuing.
REQ-024 lut_a_poly SHALL be 0 in IDLE and DONE.
REQ-025 Changes on a_in/b_in after capture SHALL have no effect on the operation in progress.

Reset
REQ-026 While rst=1 at a clock edge, SHALL set state=IDLE, busy=0, done=0, product=0, accumulator=0, mask=0, captured A/B=0.
REQ-027 Reset SHALL take priority over start and over any in-progress RUN; the aborted operation produces no done pulse.

Verification
REQ-028 a=64'h1, b=64'hFFFFFFFFFFFFFFFF, SKIP_ZERO=1 -> one RUN cycle, done in cycle 2, product=128'h0000000000000000FFFFFFFFFFFFFFFF.
REQ-029 a=0, b=any -> no RUN cycle, done in cycle 1, product=0, lut_a_poly remains 0.
REQ-030 a=b=64'hFFFFFFFFFFFFFFFF -> 4 RUN cycles, done in cycle 5, product=128'h55555555555555555555555555555555.
REQ-031 a=64'h8000000000000000, b=64'h3 -> RUN lut_a_poly=64'h780000, product=128'h18000000000000000, done in cycle 2.
REQ-032 a=b=64'hFFFFFFFFFFFFFFFF with rst pulsed in the 2nd RUN cycle -> idle, product=0, no done; then a=2, b=2 -> product=128'h4.
REQ-033 start held high across a whole operation -> a second operation starts only from IDLE, after done; new a_in/b_in applied while busy do not alter the current product.
